// File: rtl/result_stream_fifo.sv
// rtl/result_stream_fifo.sv - CPA result capture FIFO with valid/ready output stream
// Tags frame ends, keeps sticky overflow and a popped-frame counter for the control unit.
module result_stream_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [7:0]               frames
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      frames_q, frames_d;
  logic [W:0]      mem_q [DEPTH];
  logic [W:0]      head;
  logic            run, push, pop;

  assign run       = (state_q == ST_RUN);
  assign head      = mem_q[rd_ptr_q];
  assign out_data  = head[W-1:0];
  assign out_last  = head[W];
  assign count     = count_q;
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign out_valid = run && !empty;
  assign overflow  = overflow_q;
  assign frames    = frames_q;

  // clear swallows any push/pop in its own cycle
  assign pop  = out_valid && out_ready && !clear;
  assign push = run && !clear && in_valid && (!full || pop);

  always_comb begin
    state_d    = ST_RUN;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    frames_d   = frames_q;
    if (clear) begin
      state_d    = run ? ST_FLUSH : ST_RUN;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      frames_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (head[W]) frames_d = frames_q + 8'd1;
      end
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      if (run && in_valid && full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      frames_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      frames_q   <= frames_d;
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
  end

endmodule

// File: tb/tb_result_stream_fifo.sv
// tb/tb_result_stream_fifo.sv - self-checking bench for result_stream_fifo
// Queue-based reference model compared every cycle, plus directed literal checks.
module tb_result_stream_fifo;

  localparam int W = 36;
  localparam int DEPTH = 8;

  logic           clk, reset_n, clear, in_valid, in_last, out_ready;
  logic [W-1:0]   in_data, out_data;
  logic           out_valid, out_last, full, empty, overflow;
  logic [3:0]     count;
  logic [7:0]     frames;

  int total = 0;
  int bad = 0;

  result_stream_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .count(count), .full(full), .empty(empty),
    .overflow(overflow), .frames(frames)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [W-1:0] d; logic l; } ent_t;
  ent_t       mq[$];
  logic       m_ovf;
  logic [7:0] m_frm;
  logic       m_flush;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_ovf = 0;
      m_frm = 0;
      m_flush = 0;
    end else if (clear) begin
      mq.delete();
      m_ovf = 0;
      m_frm = 0;
      m_flush = !m_flush;
    end else if (m_flush) begin
      m_flush = 0;
    end else begin
      automatic bit do_pop = (mq.size() != 0) && out_ready;
      if (do_pop) begin
        if (mq[0].l) m_frm = m_frm + 8'd1;
        void'(mq.pop_front());
      end
      if (in_valid) begin
        if (mq.size() < DEPTH) mq.push_back('{d: in_data, l: in_last});
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("m_out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("m_out_data", out_data, mq[0].d);
        chk("m_out_last", out_last, mq[0].l);
      end
      chk("m_count", count, mq.size());
      chk("m_full", full, mq.size() == DEPTH);
      chk("m_empty", empty, mq.size() == 0);
      chk("m_overflow", overflow, m_ovf);
      chk("m_frames", frames, m_frm);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int exp_v;
    reset_n = 0; clear = 0; in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);

    // single word
    in_valid = 1; in_data = 36'h0_0000_00FF; in_last = 1; out_ready = 1;
    tick();
    in_valid = 0; in_last = 0;
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 36'hFF);
    chk("t1_last", out_last, 1);
    tick();
    chk("t1_empty", empty, 1);
    chk("t1_frames", frames, 1);

    // fill and drop
    out_ready = 0;
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1; in_data = W'(i);
      tick();
      if (i == 8) begin
        chk("t2_full", full, 1);
        chk("t2_count", count, 8);
        chk("t2_no_ovf", overflow, 0);
      end
    end
    in_valid = 0;
    chk("t2_ovf", overflow, 1);
    chk("t2_count9", count, 8);
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      chk("t2_drain", out_data, W'(i));
      tick();
    end
    chk("t2_empty", empty, 1);

    // full with simultaneous push and pop
    clear = 1; tick(); clear = 0; tick();
    out_ready = 0;
    exp_v = 100;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) out_ready = 1;
      in_valid = 1; in_data = W'(100 + i);
      if (out_ready) begin
        chk("t3_head", out_data, W'(exp_v));
        exp_v++;
      end
      tick();
      if (i >= 7) chk("t3_count", count, 8);
      chk("t3_ovf", overflow, 0);
    end
    in_valid = 0;
    for (int i = 0; i < 8; i++) begin
      chk("t3_valid", out_valid, 1);
      chk("t3_tail", out_data, W'(exp_v));
      exp_v++;
      tick();
    end
    chk("t3_empty", empty, 1);

    // frame counter wrap
    clear = 1; tick(); clear = 0; tick();
    in_valid = 1; in_last = 1; out_ready = 1;
    for (int i = 0; i < 256; i++) begin
      in_data = W'(i);
      tick();
    end
    in_valid = 0;
    tick();
    chk("t4_wrap", frames, 0);
    chk("t4_empty", empty, 1);
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    chk("t4_one", frames, 1);
    in_last = 0;

    // clear during traffic
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = W'(200 + i); in_last = (i == 2);
      tick();
    end
    in_last = 0;
    chk("t5_count5", count, 5);
    in_data = 36'hAA; clear = 1;
    tick();
    clear = 0;
    chk("t5_count", count, 0);
    chk("t5_ovf", overflow, 0);
    chk("t5_frames", frames, 0);
    chk("t5_valid", out_valid, 0);
    in_data = 36'hBB;
    tick();
    in_valid = 0;
    chk("t5_flush_drop", count, 0);
    chk("t5_flush_empty", empty, 1);

    // async reset mid-stream
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = W'(300 + i);
      tick();
    end
    in_valid = 0;
    chk("t6_count3", count, 3);
    #2 reset_n = 0;
    #1;
    chk("t6_valid_drop", out_valid, 0);
    chk("t6_count_rst", count, 0);
    chk("t6_empty_rst", empty, 1);
    tick();
    reset_n = 1;
    in_valid = 1; in_data = 36'h123;
    tick();
    in_valid = 0;
    chk("t6_count1", count, 1);
    chk("t6_valid", out_valid, 1);
    chk("t6_data", out_data, 36'h123);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_stream_fifo.md
# result_stream_fifo

Downstream stage of the adder-tree/CPA accumulation datapath. It captures each registered CPA result into a small synchronous FIFO and presents it on a valid/ready stream to the consumer. Frame boundaries are tagged with a last marker, and overflow and frame-count status are kept for the control unit.

## Interface
Parameters:
- `W`, default 36: result width. Equals `BITS + 4` of the datapath, i.e. `[3+BITS:0]`.
- `DEPTH`, default 8: FIFO entries. Power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush: empties FIFO, clears `overflow` and `frames`.
- `in_valid`  in  1  result word present this cycle (registered CPA result strobe, `cal` delayed one cycle).
- `in_data`  in  W  result word.
- `in_last`  in  1  word is the final result of a frame (`fin` aligned to `in_valid`).
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts head entry.
- `out_data`  out  W  head entry data.
- `out_last`  out  1  head entry last marker.
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky: a word was dropped.
- `frames`  out  8  count of popped entries with `last=1`, wrapping modulo 256.

## Operation
- **Storage:** DEPTH×(W+1) register array, holding `{last, data}`.
- **Pointers:** `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)` bits and wrap naturally. `count` is kept explicitly.
- **Push:** `push = in_valid && (!full || pop)`. Writes `{in_last, in_data}` at `wr_ptr`, then `wr_ptr++`.
- **Pop:** `pop = out_valid && out_ready`. Then `rd_ptr++`. If the popped entry has `last=1`, `frames++`, wrapping 255→0.
- **Count update:** `count` +1 on push only, −1 on pop only, unchanged on both or neither.
- **Drop:** `in_valid && full && !pop` drops the word; pointers and count are unchanged; `overflow` is set to 1 and held until `clear` or reset.
- **Output mux:** `out_valid = !empty`. `out_data`/`out_last` come combinationally from the `rd_ptr` entry. When empty they hold the stale entry; consumers must ignore them while `out_valid=0`.
- **No bypass:** a word pushed into an empty FIFO is visible on the following cycle.
- **Control FSM:** 2 states.
  - RUN: normal operation.
  - FLUSH: entered for exactly one cycle when `clear` is sampled high in RUN.
  - In the `clear` cycle itself, pointers, `count`, `overflow` and `frames` are zeroed at the edge, and any push/pop in that cycle is discarded.
  - In FLUSH, `in_valid` is ignored (drained upstream tail) and `out_valid=0`.
  - FLUSH → RUN unconditionally. `clear` held high keeps re-entering the zeroing behaviour each cycle.
- **Reset (`reset_n` low, asynchronous):** FSM=RUN, `wr_ptr=rd_ptr=count=0`, `overflow=0`, `frames=0`. Therefore `out_valid=0`, `empty=1`, `full=0`. Array contents are not reset.

## Timing
- **Latency:** `in_valid` at edge N → `out_valid=1` after edge N, so earliest pop is at edge N+1.
- **Throughput:** one push and one pop per cycle sustained. A full FIFO with `out_ready=1` accepts a new word every cycle with no drop.
- **Status timing:** `count`, `full`, `empty`, `overflow`, `frames` are registered or derived from registered state, and update at the edge following the event.
- **Ready dependence:** `out_ready` may change at any cycle. `out_valid` never depends combinationally on `out_ready`.
- **Async reset mid-transfer:** all in-flight entries are lost. Outputs go to reset values immediately, without waiting for a clock edge.
- **Clear vs. reset:** `clear` has priority over push and pop. `reset_n` has priority over everything.

## Test plan
1. **Reset and single word:** reset, then one push of `in_data=36'h0_0000_00FF` with `in_last=1`, `out_ready=1`.
   - The cycle after the push: `out_valid=1`, `out_data=FF`, `out_last=1`.
   - The following cycle: `empty=1`, `frames=1`.
2. **Fill and drop:** `out_ready=0`, push values 1..9 on consecutive cycles (DEPTH=8).
   - After 8 pushes: `full=1`, `count=8`.
   - Ninth word is dropped; `overflow=1`.
   - Draining yields exactly 1..8 in order.
3. **Full with simultaneous push and pop:** from full, hold `out_ready=1` and push 100..115.
   - No drop, `overflow` stays 0, `count` stays 8.
   - Output sequence continues in order with no gaps.
4. **Frame wrap:** 256 single-word frames, each with `last=1`, pushed and popped.
   - `frames` wraps to 0.
   - One more frame → `frames=1`.
5. **Clear during traffic:** with 5 entries queued and `in_valid=1`, pulse `clear` for one cycle.
   - Next cycle: `count=0`, `overflow=0`, `frames=0`, `out_valid=0`.
   - The word presented during the FLUSH cycle is not stored.
6. **Async reset mid-stream:** drop `reset_n` between clock edges with 3 entries queued.
   - `out_valid` falls immediately.
   - After release, the first new push appears with `count=1`.
